store_buffer: RTL and testbench



---
 rtl/store_buffer_pkg.sv | 49 ++++
 rtl/sb_forward_match.sv | 46 ++++
 rtl/store_buffer.sv | 193 +++++++++++++++++++
 tb/tb_store_buffer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
// Shared types and constants for the store buffer that sits after write-back.
// Holds the drain FSM state encoding, the layout of one buffered store, and
// the D-cache request tag that every store-buffer write carries.
// No ports (package).

package store_buffer_pkg;

  // Default geometry of the store path; the top-level parameters default to these.
  localparam int SB_ADDR_W = 64;
  localparam int SB_DATA_W = 64;
  localparam int SB_TAG_W  = 13;

  // Drain state machine: idle, request presented, waiting for the write to complete.
  typedef enum logic [1:0] {
    SB_IDLE     = 2'd0,
    SB_REQ      = 2'd1,
    SB_WAIT_ACK = 2'd2
  } sb_state_t;

  // One committed store waiting to reach the D-cache.
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  // D-cache interface tag field encodings.
  typedef enum logic [1:0] {
    CACHE_OP_NONE  = 2'b00,
    CACHE_OP_READ  = 2'b01,
    CACHE_OP_WRITE = 2'b10,
    CACHE_OP_FLUSH = 2'b11
  } cache_op_t;

  typedef enum logic [1:0] {
    CACHE_SPACE_IO     = 2'b00,
    CACHE_SPACE_MEMORY = 2'b01
  } cache_space_t;

  typedef enum logic [1:0] {
    CACHE_KIND_INSTR = 2'b00,
    CACHE_KIND_DATA  = 2'b01
  } cache_kind_t;

  // Every store-buffer request is a data write to memory; low bits are unused id space.
  localparam logic [SB_TAG_W-1:0] SB_WRITE_TAG =
    {CACHE_OP_WRITE, CACHE_SPACE_MEMORY, CACHE_KIND_DATA, 7'b0};

endpackage

// File: rtl/sb_forward_match.sv
// sb_forward_match
// Age-ordered address matcher used for store-to-load forwarding. Finds the
// youngest valid entry whose address equals the lookup address.
// Ports:
//   entries_i  buffered stores (array indexed by physical slot)
//   valid_i    per-slot valid mask
//   head_i     slot of the oldest entry
//   addr_i     address to look up
//   hit_o      some valid entry matches
//   index_o    slot of the youngest matching entry (head_i when no hit)

module sb_forward_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                    entries_i [DEPTH],
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [SB_ADDR_W-1:0]         addr_i,
  output logic                         hit_o,
  output logic [$clog2(DEPTH)-1:0]     index_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] slotMatch;

  // Per-slot exact address compare, masked by validity.
  for (genvar g = 0; g < DEPTH; g++) begin : gen_match
    assign slotMatch[g] = valid_i[g] && (entries_i[g].addr == addr_i);
  end

  // Walk from oldest to youngest; the last match seen is the youngest one.
  always_comb begin
    hit_o   = 1'b0;
    index_o = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      if (slotMatch[head_i + PTR_W'(k)]) begin
        hit_o   = 1'b1;
        index_o = head_i + PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
// Small FIFO of committed stores between write-back and the D-cache. Write-back
// retires stores into the buffer; a drain FSM writes them to the cache in order
// with the reqcyc/reqack/writeack handshake; younger loads get forwarded data
// from the youngest pending store to the same address.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   push_valid/ready/addr/data  store push from write-back
//   lookup_addr/hit/data        combinational forwarding lookup
//   empty, occupancy            buffer status
//   reqcyc/req/reqdata/reqtag   D-cache write request
//   reqack, writeack            D-cache accept / write completion

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int TAG_W  = SB_TAG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     reqcyc,
  output logic [ADDR_W-1:0]        req,
  output logic [DATA_W-1:0]        reqdata,
  output logic [TAG_W-1:0]         reqtag,
  input  logic                     reqack,
  input  logic                     writeack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  sb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] headPtr_q, tailPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  sb_state_t        state_q, state_d;

  logic              reqcyc_q, reqcyc_d;
  logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
  logic [DATA_W-1:0] reqData_q, reqData_d;
  logic [TAG_W-1:0]  reqTag_q, reqTag_d;

  logic             pushFire;
  logic             popFire;
  logic [DEPTH-1:0] validMask;
  logic             matchHit;
  logic [PTR_W-1:0] matchIdx;

  // A full buffer refuses pushes even when a pop lands on the same edge, so
  // readiness depends only on the registered count.
  assign push_ready = (count_q != FULL_COUNT);
  assign pushFire   = push_valid && push_ready;
  assign empty      = (count_q == '0);
  assign occupancy  = count_q;

  assign reqcyc  = reqcyc_q;
  assign req     = reqAddr_q;
  assign reqdata = reqData_q;
  assign reqtag  = reqTag_q;

  // Storage slots are only ever read while valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (pushFire) begin
      entries_q[tailPtr_q] <= '{addr: push_addr, data: push_data};
    end
  end

  // Drain FSM: load the head entry into the request registers from IDLE, hold
  // it through REQ, and pop on writeack (which may coincide with reqack).
  always_comb begin
    state_d   = state_q;
    reqcyc_d  = reqcyc_q;
    reqAddr_d = reqAddr_q;
    reqData_d = reqData_q;
    reqTag_d  = reqTag_q;
    popFire   = 1'b0;
    case (state_q)
      SB_IDLE: begin
        if (count_q != '0) begin
          state_d   = SB_REQ;
          reqcyc_d  = 1'b1;
          reqAddr_d = entries_q[headPtr_q].addr;
          reqData_d = entries_q[headPtr_q].data;
          reqTag_d  = SB_WRITE_TAG;
        end
      end
      SB_REQ: begin
        if (reqack) begin
          reqcyc_d = 1'b0;
          if (writeack) begin
            popFire = 1'b1;
            state_d = SB_IDLE;
          end else begin
            state_d = SB_WAIT_ACK;
          end
        end
      end
      SB_WAIT_ACK: begin
        if (writeack) begin
          popFire = 1'b1;
          state_d = SB_IDLE;
        end
      end
      default: begin
        state_d  = SB_IDLE;
        reqcyc_d = 1'b0;
      end
    endcase
  end

  // Occupancy bookkeeping; a simultaneous push and pop leaves the count alone.
  always_comb begin
    count_d = count_q;
    unique case ({pushFire, popFire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, count, FSM state and request registers; reset abandons any
  // in-flight cache transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
      state_q   <= SB_IDLE;
      reqcyc_q  <= 1'b0;
      reqAddr_q <= '0;
      reqData_q <= '0;
      reqTag_q  <= '0;
    end else begin
      if (pushFire) begin
        tailPtr_q <= tailPtr_q + PTR_W'(1);
      end
      if (popFire) begin
        headPtr_q <= headPtr_q + PTR_W'(1);
      end
      count_q   <= count_d;
      state_q   <= state_d;
      reqcyc_q  <= reqcyc_d;
      reqAddr_q <= reqAddr_d;
      reqData_q <= reqData_d;
      reqTag_q  <= reqTag_d;
    end
  end

  // A slot is valid when its distance from head (mod DEPTH) is below count;
  // the head stays valid while its write is in flight.
  for (genvar g = 0; g < DEPTH; g++) begin : gen_valid
    logic [PTR_W-1:0] age;
    assign age          = PTR_W'(g) - headPtr_q;
    assign validMask[g] = ({1'b0, age} < count_q);
  end

  sb_forward_match #(
    .DEPTH (DEPTH)
  ) u_forward_match (
    .entries_i (entries_q),
    .valid_i   (validMask),
    .head_i    (headPtr_q),
    .addr_i    (lookup_addr),
    .hit_o     (matchHit),
    .index_o   (matchIdx)
  );

  assign lookup_hit  = matchHit;
  assign lookup_data = matchHit ? entries_q[matchIdx].data : '0;

  // Internal consistency checks.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (reset) (count_q == FULL_COUNT) |-> !pushFire
  );

  a_req_stable: assert property (
    @(posedge clk) disable iff (reset)
      (reqcyc && !reqack) |=> ($stable(req) && $stable(reqdata))
  );

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
// Directed bench for store_buffer with a queue-based reference model checked
// every cycle, plus hand-computed literal expectations for key scenarios.

module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 13;
  localparam logic [TAG_W-1:0] EXP_TAG = 13'h1280;

  logic              clk = 1'b0;
  logic              reset;
  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic              empty;
  logic [2:0]        occupancy;
  logic              reqcyc;
  logic [ADDR_W-1:0] req;
  logic [DATA_W-1:0] reqdata;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack;
  logic              writeack;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } storeRec;

  storeRec     modelQ[$];
  bit          modelReqOut;
  bit          modelAwaitWrite;
  bit          popNow;
  bit          pushNow;
  logic        expHit;
  logic [63:0] expData;

  int assertCount = 0;
  int failCount   = 0;
  bit sawFull     = 1'b0;

  store_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .empty       (empty),
    .occupancy   (occupancy),
    .reqcyc      (reqcyc),
    .req         (req),
    .reqdata     (reqdata),
    .reqtag      (reqtag),
    .reqack      (reqack),
    .writeack    (writeack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference model: advance on each rising edge from the inputs, then compare
  // the settled DUT outputs a few time units later.
  always @(posedge clk) begin
    if (reset) begin
      modelQ.delete();
      modelReqOut     = 1'b0;
      modelAwaitWrite = 1'b0;
    end else begin
      popNow  = (modelReqOut && reqack && writeack) || (modelAwaitWrite && writeack);
      pushNow = push_valid && (modelQ.size() < DEPTH);
      if (modelReqOut) begin
        if (reqack) begin
          modelReqOut     = 1'b0;
          modelAwaitWrite = !writeack;
        end
      end else if (modelAwaitWrite) begin
        if (writeack) modelAwaitWrite = 1'b0;
      end else if (modelQ.size() > 0) begin
        modelReqOut = 1'b1;
      end
      if (popNow) void'(modelQ.pop_front());
      if (pushNow) modelQ.push_back('{addr: push_addr, data: push_data});
    end
    #3;
    checkOutput("model occupancy", 64'(occupancy), 64'(modelQ.size()));
    checkOutput("model empty", 64'(empty), 64'(modelQ.size() == 0));
    checkOutput("model push_ready", 64'(push_ready), 64'(modelQ.size() != DEPTH));
    checkOutput("model reqcyc", 64'(reqcyc), 64'(modelReqOut));
    if (modelReqOut && modelQ.size() > 0) begin
      checkOutput("model req", req, modelQ[0].addr);
      checkOutput("model reqdata", reqdata, modelQ[0].data);
      checkOutput("model reqtag", 64'(reqtag), 64'(EXP_TAG));
    end
    expHit  = 1'b0;
    expData = '0;
    for (int i = modelQ.size() - 1; i >= 0; i--) begin
      if (modelQ[i].addr == lookup_addr) begin
        expHit  = 1'b1;
        expData = modelQ[i].data;
        break;
      end
    end
    checkOutput("model lookup_hit", 64'(lookup_hit), 64'(expHit));
    checkOutput("model lookup_data", lookup_data, expData);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic pv, input logic [63:0] a, input logic [63:0] d);
    push_valid = pv;
    push_addr  = a;
    push_data  = d;
  endtask

  // Present a store and hold it until the buffer takes it.
  task automatic pushStore(input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    applyStimulus(1'b1, a, d);
    while (!push_ready && n < 200) begin
      if (occupancy == 3'd4) sawFull = 1'b1;
      tick();
      n++;
    end
    checkOutput("push accepted", 64'(push_ready), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0);
  endtask

  task automatic waitReqcyc(input string name);
    int n = 0;
    while (!reqcyc && n < 100) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(reqcyc), 64'd1);
  endtask

  // Complete one cache write: reqack after ackDelay cycles, writeack wrDelay
  // cycles after reqack (0 means in the same cycle).
  task automatic serviceOne(input int ackDelay, input int wrDelay, output logic [63:0] seenAddr);
    waitReqcyc("drain reqcyc raised");
    repeat (ackDelay) tick();
    seenAddr = req;
    reqack   = 1'b1;
    writeack = (wrDelay == 0);
    tick();
    reqack   = 1'b0;
    writeack = 1'b0;
    if (wrDelay > 0) begin
      repeat (wrDelay - 1) tick();
      writeack = 1'b1;
      tick();
      writeack = 1'b0;
    end
  endtask

  task automatic drainAll();
    logic [63:0] seen;
    for (int n = 0; n < DEPTH + 2 && occupancy != 0; n++) serviceOne(0, 1, seen);
    checkOutput("drain leaves empty", 64'(empty), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] seenAddr [6];
    logic [63:0] expAddr  [6];
    expAddr = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50, 64'h60};

    reset = 1'b1;
    applyStimulus(1'b0, '0, '0);
    lookup_addr = '0;
    reqack      = 1'b0;
    writeack    = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset empty", 64'(empty), 64'd1);
    checkOutput("reset occupancy", 64'(occupancy), 64'd0);
    checkOutput("reset push_ready", 64'(push_ready), 64'd1);
    checkOutput("reset reqcyc", 64'(reqcyc), 64'd0);
    checkOutput("reset req", req, 64'd0);
    checkOutput("reset reqtag", 64'(reqtag), 64'd0);
    checkOutput("reset lookup_hit", 64'(lookup_hit), 64'd0);

    $display("[TB] single store");
    applyStimulus(1'b1, 64'h1000, 64'hDEAD);
    lookup_addr = 64'h1000;
    #1;
    checkOutput("t1 no forward before push", 64'(lookup_hit), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("t1 forward hit", 64'(lookup_hit), 64'd1);
    checkOutput("t1 forward data", lookup_data, 64'hDEAD);
    checkOutput("t1 reqcyc cycle1", 64'(reqcyc), 64'd0);
    tick();
    checkOutput("t1 reqcyc cycle2", 64'(reqcyc), 64'd1);
    checkOutput("t1 req", req, 64'h1000);
    checkOutput("t1 reqdata", reqdata, 64'hDEAD);
    checkOutput("t1 reqtag", 64'(reqtag), 64'h1280);
    repeat (3) tick();
    reqack = 1'b1;
    checkOutput("t1 reqcyc held", 64'(reqcyc), 64'd1);
    tick();
    reqack = 1'b0;
    checkOutput("t1 reqcyc dropped", 64'(reqcyc), 64'd0);
    checkOutput("t1 occupancy waiting", 64'(occupancy), 64'd1);
    writeack = 1'b1;
    tick();
    writeack = 1'b0;
    checkOutput("t1 empty after write", 64'(empty), 64'd1);
    checkOutput("t1 occupancy after write", 64'(occupancy), 64'd0);
    checkOutput("t1 no forward after pop", 64'(lookup_hit), 64'd0);

    $display("[TB] fill and wrap");
    fork
      begin
        for (int i = 0; i < 6; i++) pushStore(64'(16 * (i + 1)), 64'(160 + i));
      end
      begin
        for (int i = 0; i < 6; i++) serviceOne(5, 5, seenAddr[i]);
      end
    join
    for (int i = 0; i < 6; i++) checkOutput($sformatf("t2 drain order %0d", i), seenAddr[i], expAddr[i]);
    checkOutput("t2 saw full", 64'(sawFull), 64'd1);
    checkOutput("t2 empty at end", 64'(empty), 64'd1);

    $display("[TB] forwarding");
    pushStore(64'h200, 64'h11);
    pushStore(64'h200, 64'h22);
    pushStore(64'h300, 64'h33);
    lookup_addr = 64'h200;
    #1;
    checkOutput("t3 youngest hit", 64'(lookup_hit), 64'd1);
    checkOutput("t3 youngest data", lookup_data, 64'h22);
    lookup_addr = 64'h208;
    #1;
    checkOutput("t3 miss hit", 64'(lookup_hit), 64'd0);
    checkOutput("t3 miss data", lookup_data, 64'd0);
    lookup_addr = 64'h300;
    #1;
    checkOutput("t3 other data", lookup_data, 64'h33);
    serviceOne(1, 1, seenAddr[0]);
    lookup_addr = 64'h200;
    #1;
    checkOutput("t3 after first pop data", lookup_data, 64'h22);
    serviceOne(1, 1, seenAddr[0]);
    #1;
    checkOutput("t3 after second pop hit", 64'(lookup_hit), 64'd0);
    drainAll();

    $display("[TB] same-cycle acks");
    pushStore(64'h400, 64'h41);
    pushStore(64'h410, 64'h42);
    pushStore(64'h420, 64'h43);
    waitReqcyc("t4 reqcyc raised");
    reqack   = 1'b1;
    writeack = 1'b1;
    tick();
    reqack   = 1'b0;
    writeack = 1'b0;
    checkOutput("t4 idle gap reqcyc", 64'(reqcyc), 64'd0);
    checkOutput("t4 occupancy after pop", 64'(occupancy), 64'd2);
    tick();
    checkOutput("t4 reissue reqcyc", 64'(reqcyc), 64'd1);
    checkOutput("t4 reissue req", req, 64'h410);
    applyStimulus(1'b1, 64'h430, 64'h44);
    reqack   = 1'b1;
    writeack = 1'b1;
    tick();
    applyStimulus(1'b0, '0, '0);
    reqack   = 1'b0;
    writeack = 1'b0;
    checkOutput("t4 push+pop occupancy", 64'(occupancy), 64'd2);
    tick();
    checkOutput("t4 next req", req, 64'h420);
    lookup_addr = 64'h430;
    #1;
    checkOutput("t4 pushed data visible", lookup_data, 64'h44);
    drainAll();

    $display("[TB] reset mid-transfer");
    pushStore(64'h500, 64'h51);
    waitReqcyc("t5 reqcyc raised");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5 async reqcyc", 64'(reqcyc), 64'd0);
    checkOutput("t5 async empty", 64'(empty), 64'd1);
    tick();
    tick();
    reset = 1'b0;
    pushStore(64'h600, 64'h61);
    pushStore(64'h610, 64'h62);
    pushStore(64'h620, 64'h63);
    waitReqcyc("t5 second reqcyc raised");
    reqack = 1'b1;
    tick();
    reqack = 1'b0;
    checkOutput("t5 waiting occupancy", 64'(occupancy), 64'd3);
    #2;
    reset = 1'b1;
    lookup_addr = 64'h600;
    #1;
    checkOutput("t5 reset empty", 64'(empty), 64'd1);
    checkOutput("t5 reset occupancy", 64'(occupancy), 64'd0);
    checkOutput("t5 reset lookup", 64'(lookup_hit), 64'd0);
    tick();
    tick();
    reset    = 1'b0;
    writeack = 1'b1;
    tick();
    writeack = 1'b0;
    checkOutput("t5 late writeack occupancy", 64'(occupancy), 64'd0);
    tick();
    checkOutput("t5 stays idle", 64'(reqcyc), 64'd0);

    $display("[TB] full-buffer pop/push");
    pushStore(64'h700, 64'h71);
    pushStore(64'h710, 64'h72);
    pushStore(64'h720, 64'h73);
    pushStore(64'h730, 64'h74);
    checkOutput("t6 occupancy full", 64'(occupancy), 64'd4);
    checkOutput("t6 push_ready full", 64'(push_ready), 64'd0);
    waitReqcyc("t6 reqcyc raised");
    reqack = 1'b1;
    tick();
    reqack   = 1'b0;
    writeack = 1'b1;
    applyStimulus(1'b1, 64'h740, 64'h75);
    checkOutput("t6 refused on pop cycle", 64'(push_ready), 64'd0);
    tick();
    writeack = 1'b0;
    checkOutput("t6 occupancy after pop", 64'(occupancy), 64'd3);
    checkOutput("t6 ready after pop", 64'(push_ready), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("t6 occupancy refilled", 64'(occupancy), 64'd4);
    lookup_addr = 64'h740;
    #1;
    checkOutput("t6 refill visible", lookup_data, 64'h75);
    drainAll();

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
